// File: rtl/dram_byte_writer_if.sv
// dram_byte_writer_if: bundle-side and DRAM-side handshake signals of dram_byte_writer.
//   in_en/in_addr/in_data/in_ready           : 8-lane byte-write bundle from the serializer
//   mem_wr_valid/addr/data/mem_wr_ready      : one-byte-per-beat DRAM write channel
//   master modport : the producer/consumer environment around the writer
//   slave modport  : the writer itself
interface dram_byte_writer_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [7:0]              in_en;
  logic [7:0][ADDR_W-1:0]  in_addr;
  logic [7:0][7:0]         in_data;
  logic                    in_ready;
  logic                    mem_wr_valid;
  logic [ADDR_W-1:0]       mem_wr_addr;
  logic [7:0]              mem_wr_data;
  logic                    mem_wr_ready;

  modport master (
    output in_en, in_addr, in_data, mem_wr_ready,
    input  in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  in_en, in_addr, in_data, mem_wr_ready,
    output in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/dram_byte_writer.sv
// dram_byte_writer: compacts enabled lanes of an 8-lane byte-write bundle into a
// show-ahead byte FIFO and drains it one byte per beat to the DRAM write channel.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   bus         : dram_byte_writer_if.slave (bundle input + DRAM write channel)
//   count       : bytes currently queued
//   idle        : count == 0
//   overflow    : sticky, a non-empty bundle was offered while in_ready was low
//   stat_bytes  : drained-byte counter (saturating)
// Build option: define DRAM_BYTE_WRITER_STATS_EN to enable the stat_bytes counter;
// when undefined stat_bytes is tied to zero.
module dram_byte_writer #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  dram_byte_writer_if.slave          bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       idle,
  output logic                       overflow,
  output logic [31:0]                stat_bytes
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LANES = 8;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [7:0]        data_mem_q [DEPTH];
  logic [7:0]        data_mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              any_en;
  logic              in_ready_c;
  logic              push;
  logic              pop;
  logic [3:0]        push_cnt;
  logic [PTR_W-1:0]  slot;

  // Acceptance depends only on the registered count, never on this cycle's pop.
  assign any_en     = |bus.in_en;
  assign in_ready_c = (count_q <= CNT_W'(DEPTH - LANES));
  assign push       = any_en && in_ready_c;
  assign pop        = (count_q != '0) && bus.mem_wr_ready;
  assign push_cnt   = 4'($countones(bus.in_en));

  // Lane compaction: enabled lanes land in consecutive slots from wr_ptr, wrapping.
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    slot       = wr_ptr_q;
    if (push) begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (bus.in_en[k]) begin
          addr_mem_d[slot] = bus.in_addr[k];
          data_mem_d[slot] = bus.in_data[k];
          slot             = slot + PTR_W'(1);
        end
      end
    end
  end

  // Pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + (push ? CNT_W'(push_cnt) : CNT_W'(0)) - CNT_W'(pop);
    if (any_en && !in_ready_c) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  // Show-ahead head: all driven from registered state only.
  assign bus.in_ready     = in_ready_c;
  assign bus.mem_wr_valid = (count_q != '0);
  assign bus.mem_wr_addr  = addr_mem_q[rd_ptr_q];
  assign bus.mem_wr_data  = data_mem_q[rd_ptr_q];
  assign count            = count_q;
  assign idle             = (count_q == '0);
  assign overflow         = overflow_q;

`ifdef DRAM_BYTE_WRITER_STATS_EN
  logic [31:0] stat_q, stat_d;

  // Saturating count of popped beats.
  always_comb begin
    stat_d = stat_q;
    if (pop && (stat_q != 32'hFFFF_FFFF)) begin
      stat_d = stat_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_bytes = stat_q;
`else
  assign stat_bytes = 32'h0;
`endif

endmodule
